// File: rtl/uart_word_sender_pkg.sv
// uart_word_sender_pkg: shared FSM encoding, counter width and address-width helper
package uart_word_sender_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP} state_t;
  localparam int CNT_W = 16;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_word_sender_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with flush, full/empty/count
module sync_fifo
  import uart_word_sender_pkg::*;
#(
  parameter int W = 16,
  parameter int DEPTH = 8,
  localparam int AW = clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic wr, rd;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign rd_data = mem_q[rp_q];
  assign wr = wr_en && !full && !flush;
  assign rd = rd_en && !empty && !flush;
  // next pointers and occupancy; flush wins over any concurrent access
  always_comb begin
    wp_d = flush ? '0 : wp_q + AW'(wr);
    rp_d = flush ? '0 : rp_q + AW'(rd);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
  end
  // pointer and count registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  // storage needs no reset; empty/count guard every read
  always_ff @(posedge clk)
    if (wr) mem_q[wp_q] <= wr_data;
endmodule

// File: rtl/uart_word_sender.sv
// uart_word_sender: buffers 16-bit words and feeds them bytewise to a UART transmitter
module uart_word_sender
  import uart_word_sender_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP_CYCLES = 4,
  parameter int START_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        bps_start,
  input  logic        flush,
  output logic        busy,
  output logic [15:0] bytes_sent,
  output logic        err_timeout
);
  localparam int AW = clog2(FIFO_DEPTH);
  state_t state_q, state_d;
  logic [15:0] word_q, word_d, sent_q, sent_d, fifo_rd;
  logic [7:0] tx_data_q, tx_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sel_q, sel_d, tx_start_q, tx_start_d, err_q, err_d, drop_q, drop_d;
  logic pop, fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  sync_fifo #(.W(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .wr_en(in_valid),
    .wr_data(in_data),
    .rd_en(pop),
    .rd_data(fifo_rd),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
  assign in_ready = !fifo_full;
  assign busy = state_q != IDLE || fifo_count != '0;
  assign tx_data = tx_data_q;
  assign tx_start = tx_start_q;
  assign bytes_sent = sent_q;
  assign err_timeout = err_q;
  // byte sequencer: a frame in flight always completes; drop_q remembers a flush seen meanwhile
  always_comb begin
    state_d = state_q;
    word_d = word_q;
    sel_d = sel_q;
    tx_data_d = tx_data_q;
    tx_start_d = 1'b0;
    cnt_d = cnt_q;
    sent_d = sent_q;
    err_d = err_q;
    drop_d = drop_q;
    pop = 1'b0;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (!fifo_empty && !flush && !bps_start) begin
          pop = 1'b1;
          word_d = fifo_rd;
          sel_d = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        tx_data_d = (sel_q ^ MSB_FIRST) ? word_q[15:8] : word_q[7:0];
        state_d = flush ? IDLE : START;
      end
      START: begin
        tx_start_d = !flush;
        cnt_d = '0;
        state_d = flush ? IDLE : WAIT_BUSY;
      end
      WAIT_BUSY: begin
        drop_d = drop_q || flush;
        if (bps_start) state_d = WAIT_DONE;
        else if (32'(cnt_q) == START_TIMEOUT) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else cnt_d = cnt_q + 1'b1;
      end
      WAIT_DONE: begin
        drop_d = drop_q || flush;
        if (!bps_start) begin
          sent_d = sent_q + 1'b1;
          cnt_d = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (flush) state_d = IDLE;
        else if (32'(cnt_q) + 32'd1 >= GAP_CYCLES) begin
          state_d = (sel_q || drop_q) ? IDLE : LOAD;
          sel_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      word_q <= '0;
      sel_q <= 1'b0;
      tx_data_q <= '0;
      tx_start_q <= 1'b0;
      cnt_q <= '0;
      sent_q <= '0;
      err_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      sel_q <= sel_d;
      tx_data_q <= tx_data_d;
      tx_start_q <= tx_start_d;
      cnt_q <= cnt_d;
      sent_q <= sent_d;
      err_q <= err_d;
      drop_q <= drop_d;
    end
endmodule
